// File: rtl/reg_file_pkg.sv
// Shared register-file / reorder-buffer constants, tag type and commit payload.
package reg_file_pkg;

  localparam int unsigned REG_NUM_WIDTH  = 5;
  localparam int unsigned ROB_SIZE_WIDTH = 5;
  localparam int unsigned TAG_WIDTH      = ROB_SIZE_WIDTH + 1;
  localparam int unsigned REG_NUM        = 1 << REG_NUM_WIDTH;
  localparam int unsigned DATA_WIDTH     = 32;

  typedef logic [TAG_WIDTH-1:0]      tag_t;
  typedef logic [REG_NUM_WIDTH-1:0]  reg_idx_t;
  typedef logic [ROB_SIZE_WIDTH-1:0] rob_id_t;
  typedef logic [DATA_WIDTH-1:0]     data_t;

  // All-ones tag: no pending producer (shared with the reorder buffer).
  localparam tag_t TAG_NONE = '1;

  // One commit beat from the reorder buffer.
  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    data_t    value;
    tag_t     dependency;
  } commit_t;

  // A live ROB slot always has the tag MSB clear, so it never aliases TAG_NONE.
  function automatic tag_t rob_tag(input rob_id_t id);
    return {1'b0, id};
  endfunction

endpackage

// File: rtl/reg_file_rf_read_port.sv
// One operand read port: resolves a source register to a value or pending tag.
//   rs          source register index
//   tag         current rename tag of rs
//   reg_value   architectural value of rs
//   commit      same-cycle commit beat (bypass source)
//   found       ROB already holds the producer's result
//   found_value that result
//   val / dep   resolved value, or outstanding tag (TAG_NONE when val is valid)
module reg_file_rf_read_port
  import reg_file_pkg::*;
(
  input  reg_idx_t rs,
  input  tag_t     tag,
  input  data_t    reg_value,
  input  commit_t  commit,
  input  logic     found,
  input  data_t    found_value,
  output data_t    val,
  output tag_t     dep
);

  // Priority: x0, settled register, commit bypass, ROB forward, still pending.
  always_comb begin
    val = '0;
    dep = tag;
    if (rs == '0) begin
      dep = TAG_NONE;
    end else if (tag == TAG_NONE) begin
      val = reg_value;
      dep = TAG_NONE;
    end else if (commit.valid && (commit.rd == rs) && (commit.dependency == tag)) begin
      val = commit.value;
      dep = TAG_NONE;
    end else if (found) begin
      val = found_value;
      dep = TAG_NONE;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
//   clk_in, rst_in (sync, active-low), rdy_in (global enable)
//   dec_*          issue-side rename and rs1/rs2 lookup
//   rob2rf_ready, rob_rd, rob_value, rob_dependency   commit stream
//   need_flush_in  mispredict flush
//   rob_is_found_N / rob_valueN   ROB forward for pending producers
//   rf_dependencyN current tag of dec_rsN, sent to the ROB
//   valN_out / depN_out           resolved operand value or pending tag
module reg_file
  import reg_file_pkg::*;
(
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        dec_valid,
  input  logic [REG_NUM_WIDTH-1:0]    dec_rd,
  input  logic [ROB_SIZE_WIDTH-1:0]   dec_rob_id,
  input  logic [REG_NUM_WIDTH-1:0]    dec_rs1,
  input  logic [REG_NUM_WIDTH-1:0]    dec_rs2,
  input  logic                        rob2rf_ready,
  input  logic [REG_NUM_WIDTH-1:0]    rob_rd,
  input  logic [31:0]                 rob_value,
  input  logic [ROB_SIZE_WIDTH:0]     rob_dependency,
  input  logic                        need_flush_in,
  input  logic                        rob_is_found_1,
  input  logic [31:0]                 rob_value1,
  input  logic                        rob_is_found_2,
  input  logic [31:0]                 rob_value2,
  output logic [ROB_SIZE_WIDTH:0]     rf_dependency1,
  output logic [ROB_SIZE_WIDTH:0]     rf_dependency2,
  output logic [31:0]                 val1_out,
  output logic [ROB_SIZE_WIDTH:0]     dep1_out,
  output logic [31:0]                 val2_out,
  output logic [ROB_SIZE_WIDTH:0]     dep2_out
);

  data_t   value_q [REG_NUM];
  tag_t    tag_q   [REG_NUM];
  commit_t commit;

  assign commit = '{valid: rob2rf_ready, rd: rob_rd, value: rob_value,
                    dependency: rob_dependency};

  // Commit, then flush, then issue; later steps override earlier tag writes.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        value_q[reg_idx_t'(i)] <= '0;
        tag_q[reg_idx_t'(i)]   <= TAG_NONE;
      end
    end else if (rdy_in) begin
      if (rob2rf_ready && (rob_rd != '0)) begin
        value_q[rob_rd] <= rob_value;
        // A stale commit (register renamed again since) keeps the newer tag.
        if (tag_q[rob_rd] == rob_dependency) begin
          tag_q[rob_rd] <= TAG_NONE;
        end
      end
      if (need_flush_in) begin
        for (int unsigned i = 1; i < REG_NUM; i++) begin
          tag_q[reg_idx_t'(i)] <= TAG_NONE;
        end
      end else if (dec_valid && (dec_rd != '0)) begin
        tag_q[dec_rd] <= rob_tag(dec_rob_id);
      end
    end
  end

  assign rf_dependency1 = tag_q[dec_rs1];
  assign rf_dependency2 = tag_q[dec_rs2];

  reg_file_rf_read_port u_port1 (
    .rs          (dec_rs1),
    .tag         (tag_q[dec_rs1]),
    .reg_value   (value_q[dec_rs1]),
    .commit      (commit),
    .found       (rob_is_found_1),
    .found_value (rob_value1),
    .val         (val1_out),
    .dep         (dep1_out)
  );

  reg_file_rf_read_port u_port2 (
    .rs          (dec_rs2),
    .tag         (tag_q[dec_rs2]),
    .reg_value   (value_q[dec_rs2]),
    .commit      (commit),
    .found       (rob_is_found_2),
    .found_value (rob_value2),
    .val         (val2_out),
    .dep         (dep2_out)
  );

endmodule

// File: tb/tb_reg_file.sv
// Directed table-driven bench for reg_file: each record drives one cycle and
// checks the combinational read outputs just before that cycle's rising edge.
module tb_reg_file;

  localparam logic [5:0] T = 6'h3F;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        dec_valid = 1'b0;
  logic [4:0]  dec_rd = '0;
  logic [4:0]  dec_rob_id = '0;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic        rob2rf_ready = 1'b0;
  logic [4:0]  rob_rd = '0;
  logic [31:0] rob_value = '0;
  logic [5:0]  rob_dependency = '0;
  logic        need_flush_in = 1'b0;
  logic        rob_is_found_1 = 1'b0;
  logic [31:0] rob_value1 = '0;
  logic        rob_is_found_2 = 1'b0;
  logic [31:0] rob_value2 = '0;
  logic [5:0]  rf_dependency1;
  logic [5:0]  rf_dependency2;
  logic [31:0] val1_out;
  logic [5:0]  dep1_out;
  logic [31:0] val2_out;
  logic [5:0]  dep2_out;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic        rst, rdy;
    logic        dv;
    logic [4:0]  drd, drob;
    logic [4:0]  rs1, rs2;
    logic        cm;
    logic [4:0]  rrd;
    logic [31:0] rv;
    logic [5:0]  rdep;
    logic        fl;
    logic        f1;
    logic [31:0] fv1;
    logic        f2;
    logic [31:0] fv2;
    logic        chk;
    logic [31:0] ev1;
    logic [5:0]  ed1;
    logic [31:0] ev2;
    logic [5:0]  ed2;
    logic [5:0]  er1, er2;
  } vec_t;

  reg_file dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .dec_valid      (dec_valid),
    .dec_rd         (dec_rd),
    .dec_rob_id     (dec_rob_id),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .rob2rf_ready   (rob2rf_ready),
    .rob_rd         (rob_rd),
    .rob_value      (rob_value),
    .rob_dependency (rob_dependency),
    .need_flush_in  (need_flush_in),
    .rob_is_found_1 (rob_is_found_1),
    .rob_value1     (rob_value1),
    .rob_is_found_2 (rob_is_found_2),
    .rob_value2     (rob_value2),
    .rf_dependency1 (rf_dependency1),
    .rf_dependency2 (rf_dependency2),
    .val1_out       (val1_out),
    .dep1_out       (dep1_out),
    .val2_out       (val2_out),
    .dep2_out       (dep2_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(
    input logic rst, input logic rdy,
    input logic dv, input logic [4:0] drd, input logic [4:0] drob,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic cm, input logic [4:0] rrd, input logic [31:0] rv, input logic [5:0] rdep,
    input logic fl,
    input logic f1, input logic [31:0] fv1, input logic f2, input logic [31:0] fv2,
    input logic chk,
    input logic [31:0] ev1, input logic [5:0] ed1,
    input logic [31:0] ev2, input logic [5:0] ed2,
    input logic [5:0] er1, input logic [5:0] er2);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.dv = dv; v.drd = drd; v.drob = drob;
    v.rs1 = rs1; v.rs2 = rs2; v.cm = cm; v.rrd = rrd; v.rv = rv; v.rdep = rdep;
    v.fl = fl; v.f1 = f1; v.fv1 = fv1; v.f2 = f2; v.fv2 = fv2; v.chk = chk;
    v.ev1 = ev1; v.ed1 = ed1; v.ev2 = ev2; v.ed2 = ed2; v.er1 = er1; v.er2 = er2;
    return v;
  endfunction

  task automatic check(input int idx, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL step %0d %s: got %h expected %h", idx, name, act, exp);
  endtask

  // Drive at the falling edge, check before the next rising edge.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk_in);
    rst_in = v.rst; rdy_in = v.rdy;
    dec_valid = v.dv; dec_rd = v.drd; dec_rob_id = v.drob;
    dec_rs1 = v.rs1; dec_rs2 = v.rs2;
    rob2rf_ready = v.cm; rob_rd = v.rrd; rob_value = v.rv; rob_dependency = v.rdep;
    need_flush_in = v.fl;
    rob_is_found_1 = v.f1; rob_value1 = v.fv1;
    rob_is_found_2 = v.f2; rob_value2 = v.fv2;
    #2;
    if (v.chk) begin
      check(idx, "val1", val1_out, v.ev1);
      check(idx, "dep1", 32'(dep1_out), 32'(v.ed1));
      check(idx, "val2", val2_out, v.ev2);
      check(idx, "dep2", 32'(dep2_out), 32'(v.ed2));
      check(idx, "rf_dep1", 32'(rf_dependency1), 32'(v.er1));
      check(idx, "rf_dep2", 32'(rf_dependency2), 32'(v.er2));
    end
  endtask

  initial begin
    vec_t tbl [19];
    //            rst rdy dv drd drob rs1 rs2 cm rrd rv       rdep fl f1 fv1   f2 fv2   chk ev1      ed1 ev2      ed2 er1 er2
    tbl[0]  = mk(0, 1, 0, 0, 0,  5, 0,  0, 0, 0,       0, 0,  0, 0,    0, 0,    0, 0,       T,  0,       T,  T,  T);
    tbl[1]  = mk(0, 1, 0, 0, 0,  5, 0,  0, 0, 0,       0, 0,  0, 0,    0, 0,    0, 0,       T,  0,       T,  T,  T);
    // post-reset read, issue x3 -> rob 7
    tbl[2]  = mk(1, 1, 1, 3, 7,  5, 0,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 0,       T,  0,       T,  T,  T);
    tbl[3]  = mk(1, 1, 0, 0, 0,  3, 3,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 0,       7,  0,       7,  7,  7);
    // commit bypass x3
    tbl[4]  = mk(1, 1, 0, 0, 0,  3, 3,  1, 3, 'h1234,  7, 0,  0, 0,    0, 0,    1, 'h1234,  T,  'h1234,  T,  7,  7);
    tbl[5]  = mk(1, 1, 1, 4, 2,  3, 0,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 'h1234,  T,  0,       T,  T,  T);
    tbl[6]  = mk(1, 1, 1, 4, 9,  4, 0,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 0,       2,  0,       T,  2,  T);
    // stale commit rob 2 on x4 (tag 9): no bypass, tag kept
    tbl[7]  = mk(1, 1, 0, 0, 0,  4, 0,  1, 4, 'hAA,    2, 0,  0, 0,    0, 0,    1, 0,       9,  0,       T,  9,  T);
    tbl[8]  = mk(1, 1, 1, 6, 1,  4, 0,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 0,       9,  0,       T,  9,  T);
    // commit x6 rob 1 while reissuing x6 -> rob 4
    tbl[9]  = mk(1, 1, 1, 6, 4,  6, 4,  1, 6, 'h55,    1, 0,  0, 0,    0, 0,    1, 'h55,    T,  0,       9,  1,  9);
    tbl[10] = mk(1, 1, 1, 1, 11, 6, 4,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 0,       4,  0,       9,  4,  9);
    tbl[11] = mk(1, 1, 1, 2, 12, 1, 6,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 0,       11, 0,       4,  11, 4);
    // flush with commit x1 and issue x2
    tbl[12] = mk(1, 1, 1, 2, 5,  1, 2,  1, 1, 'h10,    11, 1, 0, 0,    0, 0,    1, 'h10,    T,  0,       12, 11, 12);
    tbl[13] = mk(1, 1, 0, 0, 0,  1, 2,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 'h10,    T,  0,       T,  T,  T);
    // stale-committed x4 value now visible; issue to x0
    tbl[14] = mk(1, 1, 1, 0, 3,  4, 6,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 'hAA,    T,  'h55,    T,  T,  T);
    // commit to x0, issue x8 -> rob 3
    tbl[15] = mk(1, 1, 1, 8, 3,  0, 0,  1, 0, 'hFF,    3, 0,  0, 0,    0, 0,    1, 0,       T,  0,       T,  T,  T);
    // ROB forward on port 1; x0 ignores forward on port 2
    tbl[16] = mk(1, 1, 0, 0, 0,  8, 0,  0, 0, 0,       0, 0,  1, 'h77, 1, 'h99, 1, 'h77,    T,  0,       T,  3,  T);
    // commit bypass outranks ROB forward
    tbl[17] = mk(1, 1, 0, 0, 0,  8, 8,  1, 8, 'h88,    3, 0,  0, 0,    1, 'h66, 1, 'h88,    T,  'h88,    T,  3,  3);
    tbl[18] = mk(1, 1, 0, 0, 0,  8, 2,  0, 0, 0,       0, 0,  0, 0,    0, 0,    1, 'h88,    T,  0,       T,  T,  T);

    for (int i = 0; i < 19; i++) run_vec(i, tbl[i]);

    // rdy_in low holds state even with issue, commit and flush asserted
    run_vec(100, mk(1, 1, 1, 10, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, T, 0, T, T, T));
    run_vec(101, mk(1, 0, 1, 9, 6,   0, 0, 1, 8, 'hDEAD, T, 1, 0, 0, 0, 0, 0, 0, T, 0, T, T, T));
    run_vec(102, mk(1, 1, 0, 0, 0,   9, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, T, 0, 13, T, 13));
    // settled register outranks ROB forward
    run_vec(103, mk(1, 1, 0, 0, 0,   8, 1, 0, 0, 0, 0, 0, 1, 'h33, 1, 'h33, 1, 'h88, T, 'h10, T, T, T));

    // reset overrides a same-cycle commit and issue
    run_vec(104, mk(0, 1, 1, 5, 1,   0, 0, 1, 8, 1, T, 0, 0, 0, 0, 0, 0, 0, T, 0, T, T, T));
    run_vec(105, mk(1, 1, 0, 0, 0,   8, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, T, 0, T, T, T));
    run_vec(106, mk(1, 1, 0, 0, 0,   5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, T, 0, T, T, T));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
